// File: rtl/uart_tx.sv
// uart_tx: parameterised UART transmitter.
// Frame = start bit, LSB-first data, optional parity, one or more stop bits.
// Every bit slot lasts exactly 2*p_BITSLOT_HALF_PERIOD clock cycles.
// o_ready is registered and rises in the last cycle of the final stop bit,
// so a word offered then starts the next frame with no idle gap.
module uart_tx #(
    parameter int p_BITSLOT_HALF_PERIOD = 1,
    parameter int p_DATA_BITS           = 8,
    parameter int p_STOP_BITS           = 1,
    parameter int p_PARITY              = 0   // 0 = none, 1 = odd, 2 = even
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [p_DATA_BITS-1:0] i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic                   o_tx,
    output logic                   o_busy
);

    localparam int BIT_CYC = 2 * p_BITSLOT_HALF_PERIOD;
    localparam int CNT_W   = $clog2(BIT_CYC);
    localparam int IDX_W   = 4;

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(BIT_CYC - 2);
    localparam logic [IDX_W-1:0] DATA_LAST    = IDX_W'(p_DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST    = IDX_W'(p_STOP_BITS - 1);
    localparam logic             PAR_ODD      = (p_PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;      // cycle within the current bit slot
    logic [IDX_W-1:0]       bit_idx;  // data bit or stop bit index
    logic [p_DATA_BITS-1:0] shreg;
    logic                   par_bit;

    logic take;
    logic bit_end;

    assign take    = i_valid && o_ready;
    assign bit_end = (cnt == CNT_LAST);

    // Frame sequencer: state, bit timing, shift register and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            // NOTE: the datapath is reset as well, so an aborted frame leaves no stale word behind.
            shreg   <= '0;
            par_bit <= 1'b0;
            o_tx    <= 1'b1;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            case (state)
                S_IDLE: begin
                    o_tx    <= 1'b1;
                    o_busy  <= 1'b0;
                    o_ready <= 1'b1;
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (take) begin
                        state   <= S_START;
                        shreg   <= i_data;
                        par_bit <= (^i_data) ^ PAR_ODD;
                        o_tx    <= 1'b0;
                        o_busy  <= 1'b1;
                        o_ready <= 1'b0;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                        o_tx    <= shreg[0];
                        shreg   <= shreg >> 1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (p_PARITY != 0) begin
                                state <= S_PARITY;
                                o_tx  <= par_bit;
                            end else begin
                                state <= S_STOP;
                                o_tx  <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            o_tx    <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (bit_end) begin
                        state   <= S_STOP;
                        cnt     <= '0;
                        bit_idx <= '0;
                        o_tx    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            if (take) begin
                                // Back-to-back: next start bit follows immediately.
                                state   <= S_START;
                                shreg   <= i_data;
                                par_bit <= (^i_data) ^ PAR_ODD;
                                o_tx    <= 1'b0;
                                o_ready <= 1'b0;
                            end else begin
                                state   <= S_IDLE;
                                o_tx    <= 1'b1;
                                o_busy  <= 1'b0;
                                o_ready <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt     <= cnt + 1'b1;
                        // Raise ready so it is high exactly in the last cycle of the final stop bit.
                        o_ready <= (bit_idx == STOP_LAST) && (cnt == CNT_PRE_LAST);
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter p_BITSLOT_HALF_PERIOD, default 1: clock cycles per half bit slot; bit period is 2*p_BITSLOT_HALF_PERIOD cycles; legal range >= 1.
REQ-002 SHALL have parameter p_DATA_BITS, default 8: data bits per frame; legal range 1..16.
REQ-003 SHALL have parameter p_STOP_BITS, default 1: stop bits per frame; legal range 1..4.
REQ-004 SHALL have parameter p_PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have port i_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_data, input, p_DATA_BITS bits: word to transmit.
REQ-008 SHALL have port i_valid, input, 1 bit: i_data is valid.
REQ-009 SHALL have port o_ready, output, 1 bit: block accepts a word on this cycle.
REQ-010 SHALL have port o_tx, output, 1 bit: serial line, idle high, registered.
REQ-011 SHALL have port o_busy, output, 1 bit: a frame is in progress.

Function
REQ-012 SHALL transfer a word on each rising edge with i_valid=1 and o_ready=1; i_data is captured into an internal shift register on that edge; i_data is don't-care at all other times.
REQ-013 SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when p_PARITY=0.
REQ-014 SHALL move IDLE->START on a transfer; o_tx=0 from the next edge for exactly one bit period.
REQ-015 SHALL shift data LSB first in DATA, one bit period per bit, for exactly p_DATA_BITS bits.
REQ-016 SHALL drive the parity bit for one bit period when enabled: odd gives an odd count of ones over data plus parity; even gives an even count.
REQ-017 SHALL drive o_tx=1 for p_STOP_BITS bit periods in STOP.
REQ-018 SHALL derive all bit timing from one counter 0..2*p_BITSLOT_HALF_PERIOD-1 that is reloaded at each bit boundary; no bit may be shortened or lengthened by any cycle.
REQ-019 SHALL assert o_ready in IDLE and during the last clock cycle of the final stop bit; o_ready SHALL be 0 in all other cycles.
REQ-020 SHALL go STOP->START on a transfer in the last stop cycle, so o_tx falls on the next edge with zero idle gap (back-to-back frames).
REQ-021 SHALL go STOP->IDLE with o_tx=1 when no transfer occurs in the last stop cycle.
REQ-022 SHALL hold o_busy=1 from the edge after a transfer until the frame ends; o_busy SHALL be 0 in IDLE.
REQ-023 SHALL ignore i_valid while o_ready=0; no word is queued or lost by this rule.
REQ-024 SHALL drive o_tx only from a flop, so o_tx is glitch-free.
REQ-025 SHALL make the frame length exactly 2*p_BITSLOT_HALF_PERIOD*(1+p_DATA_BITS+(p_PARITY!=0)+p_STOP_BITS) cycles.

Reset
REQ-026 SHALL, while i_rst_n=0 and regardless of the clock, force state=IDLE, o_tx=1, o_ready=0, o_busy=0, and clear the counters and shift register.
REQ-027 SHALL assert o_ready on the first rising edge after i_rst_n deasserts.
REQ-028 SHALL abort a frame when reset occurs mid-frame: o_tx returns high immediately and the word is not resumed.

Verification
REQ-029 SHALL pass this test (H=1, 8N1): send 0xA5 -> o_tx = 0,1,0,1,0,0,1,0,1,1 with each level held 2 cycles; o_busy high 20 cycles; o_ready low 19 cycles.
REQ-030 SHALL pass this test (H=2, 8E1): send 0x03 -> parity bit 0; send 0x07 -> parity bit 1; each bit held 4 cycles; frame 44 cycles.
REQ-031 SHALL pass this test (back-to-back): hold i_valid=1 with 0x00 then 0xFF -> second start bit begins the cycle after the first stop bit ends; no idle cycle between frames.
REQ-032 SHALL pass this test (valid while busy): pulse i_valid mid-frame with o_ready=0 -> no effect on o_tx; no extra frame is sent.
REQ-033 SHALL pass this test (reset mid-frame): assert i_rst_n=0 during the DATA bit 3 -> o_tx=1 asynchronously; o_ready=1 one edge after release; a new 0x5A frame is sent correctly.
REQ-034 SHALL pass this test (H=1, p_DATA_BITS=1, p_STOP_BITS=3): send 1 -> o_tx = 0,1,1,1,1 with 2 cycles each; total 10 cycles; this frame matches the existing receiver bench settings.
